// File: rtl/latch_debounce_pkg.sv
// latch_debounce_pkg: shared FSM state type and default parameters for latch_q_debouncer
package latch_debounce_pkg;
  typedef enum logic [1:0] {IDLE_LOW, CONFIRM_HIGH, IDLE_HIGH, CONFIRM_LOW} deb_state_t;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int STABLE_CYCLES_DEF = 4;
endpackage

// File: rtl/latch_q_debouncer_sync_chain.sv
// sync_chain: async-reset (active-low) flop chain bringing an asynchronous bit into clk
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff_q;
  // shift d through STAGES flops every cycle
  always_ff @(posedge clk or negedge rst)
    if (!rst) ff_q <= '0;
    else ff_q <= {ff_q[STAGES-2:0], d};
  assign q = ff_q[STAGES-1];
endmodule

// File: rtl/latch_q_debouncer.sv
// latch_q_debouncer: synchronise and debounce latch Q, emit clean level, edge pulses and counts (optional LATCH_Q_GLITCH_CNT_EN adds glitch_cnt)
module latch_q_debouncer
  import latch_debounce_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_in,
  input  logic             en,
  input  logic             clr_cnt,
  output logic             q_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic             busy
`ifdef LATCH_Q_GLITCH_CNT_EN
  ,
  output logic [CNT_W-1:0] glitch_cnt
`endif
);
  localparam int SW = $clog2(STABLE_CYCLES);
  localparam logic [SW-1:0] LAST = SW'(STABLE_CYCLES - 1);
  logic s;
  deb_state_t state_q, state_d;
  logic [SW-1:0] stab_q, stab_d;
  logic q_q, q_d, rise_q, rise_d, fall_q, fall_d, acc, abort;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst(rst), .d(d_in), .q(s));
  // next state: a new level must survive STABLE_CYCLES confirm edges; any reversal aborts
  always_comb begin
    state_d = state_q;
    stab_d = stab_q;
    q_d = q_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    acc = 1'b0;
    abort = 1'b0;
    if (en)
      case (state_q)
        IDLE_LOW: if (s) begin state_d = CONFIRM_HIGH; stab_d = SW'(1); end
        CONFIRM_HIGH:
          if (!s) begin state_d = IDLE_LOW; stab_d = '0; abort = 1'b1; end
          else if (stab_q == LAST) begin state_d = IDLE_HIGH; stab_d = '0; q_d = 1'b1; rise_d = 1'b1; acc = 1'b1; end
          else stab_d = stab_q + 1'b1;
        IDLE_HIGH: if (!s) begin state_d = CONFIRM_LOW; stab_d = SW'(1); end
        CONFIRM_LOW:
          if (s) begin state_d = IDLE_HIGH; stab_d = '0; abort = 1'b1; end
          else if (stab_q == LAST) begin state_d = IDLE_LOW; stab_d = '0; q_d = 1'b0; fall_d = 1'b1; acc = 1'b1; end
          else stab_d = stab_q + 1'b1;
      endcase
    cnt_d = clr_cnt ? '0 : (acc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  // FSM, level, pulse and toggle counter registers
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE_LOW;
      stab_q <= '0;
      q_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      stab_q <= stab_d;
      q_q <= q_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      cnt_q <= cnt_d;
    end
`ifdef LATCH_Q_GLITCH_CNT_EN
  logic [CNT_W-1:0] gl_q, gl_d;
  assign gl_d = clr_cnt ? '0 : (abort && gl_q != '1) ? gl_q + 1'b1 : gl_q;
  // saturating count of rejected glitches
  always_ff @(posedge clk or negedge rst)
    if (!rst) gl_q <= '0;
    else gl_q <= gl_d;
  assign glitch_cnt = gl_q;
`endif
  assign q_out = q_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign toggle_cnt = cnt_q;
  assign busy = (state_q == CONFIRM_HIGH) || (state_q == CONFIRM_LOW);
endmodule

// File: doc/latch_q_debouncer.md
Name: latch_q_debouncer

Overview:
Downstream consumer of the clocked D-latch output (Q). It synchronises the latch output into the system clock domain and debounces it against a stability window. It emits a clean level plus one-cycle rise/fall pulses and keeps a saturating transition count. The block sits between the latch stage and any counter/control logic that needs glitch-free edges.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on d_in (legal ≥2)
STABLE_CYCLES, 4, consecutive synchronised cycles a new level must hold before acceptance (legal ≥2)
CNT_W, 8, width of toggle_cnt

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
d_in  input  1  latch Q output, asynchronous to clk
en  input  1  1 = FSM and counters advance; 0 = hold (synchroniser keeps running)
clr_cnt  input  1  synchronous clear of toggle_cnt
q_out  output  1  debounced level
rise_pulse  output  1  one-cycle pulse when q_out goes 0→1
fall_pulse  output  1  one-cycle pulse when q_out goes 1→0
toggle_cnt  output  CNT_W  saturating count of accepted transitions
busy  output  1  1 while in a CONFIRM state

Behaviour:
- Reset (rst=0, async): sync flops=0, state=IDLE_LOW, stab_cnt=0, q_out=0, rise/fall_pulse=0, toggle_cnt=0, busy=0. On release, first active edge behaves as normal operation.
- Synchroniser: s = d_in delayed through SYNC_STAGES flops; always clocked, ignores en.
- States: IDLE_LOW, CONFIRM_HIGH, IDLE_HIGH, CONFIRM_LOW. stab_cnt width = $clog2(STABLE_CYCLES).
- IDLE_LOW: s=1 → CONFIRM_HIGH, stab_cnt←1.
- CONFIRM_HIGH: s=0 → IDLE_LOW, stab_cnt←0 (glitch rejected); else stab_cnt==STABLE_CYCLES-1 → IDLE_HIGH, q_out←1, rise_pulse←1, toggle_cnt++; else stab_cnt++.
- IDLE_HIGH / CONFIRM_LOW: mirror image with s=0, q_out←0, fall_pulse.
- Latency: counting the first edge that samples d_in=1 as edge 1, q_out is registered high at edge SYNC_STAGES+STABLE_CYCLES (6 with defaults). Same for falls.
- Pulses are registered, high exactly one cycle, never both in the same cycle.
- busy = (state==CONFIRM_HIGH || state==CONFIRM_LOW), combinational from state.
- en=0: state, stab_cnt, q_out and toggle_cnt hold; pulses forced 0. A transition in flight resumes from the held count when en returns to 1.
- toggle_cnt saturates at 2^CNT_W-1 and never wraps.
- clr_cnt=1: toggle_cnt←0 next edge. It wins over a simultaneous increment. It is independent of en.
- Reset mid-CONFIRM: the transition is aborted. No pulse; outputs take reset values immediately.

Optional Feature:
Macro LATCH_Q_GLITCH_CNT_EN.
- Defined: extra output glitch_cnt [CNT_W-1:0]. It increments (saturating) on every CONFIRM→IDLE abort (return to the same level), is cleared by clr_cnt and by reset, and holds when en=0.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package latch_debounce_pkg: enum typedef deb_state_t {IDLE_LOW, CONFIRM_HIGH, IDLE_HIGH, CONFIRM_LOW} and the default constants (SYNC_STAGES_DEF=2, STABLE_CYCLES_DEF=4).
- One sub-module, sync_chain (parameter STAGES, ports clk, rst, d, q), holding the async-reset flop chain.
- FSM, counters and pulse registers stay in the top module.

Test Plan:
- Reset: rst=0 with d_in=1 for 5 cycles → q_out=0, toggle_cnt=0, busy=0. After release with d_in held at 1 → q_out=1 at edge 6, rise_pulse high 1 cycle, toggle_cnt=1.
- Clean edges: d_in 0→1 held 10 cycles, then 1→0 held 10 cycles (defaults) → rise at edge 6, fall 6 edges after the falling sample, toggle_cnt=2, busy high 3 cycles each.
- Glitch reject: d_in high for 3 sampled cycles then low → q_out stays 0, no pulse, toggle_cnt=0 (glitch_cnt=1 when LATCH_Q_GLITCH_CNT_EN).
- en hold: en=0 after 2 CONFIRM cycles for 5 cycles, d_in stable high → q_out rises exactly 2 cycles after en returns to 1.
- Saturation/clear: CNT_W=2, 5 accepted toggles → toggle_cnt=3. Then clr_cnt=1 on the same edge as an accepted toggle → toggle_cnt=0.
- Reset mid-CONFIRM: rst=0 during CONFIRM_HIGH → busy=0, q_out=0 immediately, no rise_pulse.
